// File: rtl/keypad_entry_pkg.sv
// Shared definitions for the keypad entry block: key codes, scan result kinds,
// debounce states and the row/column to key-code map.
package keypad_entry_pkg;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_BS  = 4'hB;
  localparam logic [3:0] KEY_ENT = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAND,
    ST_HELD,
    ST_REL
  } deb_state_t;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_SINGLE,
    SCAN_MULTI
  } scan_kind_t;

  // Raw index is row*4 + column.
  function automatic logic [3:0] keymap(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [7:0] mul10(input logic [7:0] x);
    return (x << 3) + (x << 1);
  endfunction

endpackage

// File: rtl/keypad_entry_scan.sv
// Column scanner: row synchronizer, free-running dwell counter, column strobe
// rotation and per-scan classification into none / single key / multiple keys.
module keypad_scan
  import keypad_entry_pkg::*;
#(
  parameter int SCAN_W = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       scan_done,
  output scan_kind_t scan_kind,
  output logic [3:0] scan_idx
);

  logic [3:0]        row_s1, row_s2;
  logic [SCAN_W-1:0] dwell_cnt;
  logic [1:0]        col_sel;
  logic              dwell_end;
  logic              acc_any, acc_multi;
  logic [3:0]        acc_idx;

  logic [3:0] lows;
  logic       col_any, col_multi;
  logic [1:0] first_r;
  logic       mrg_any, mrg_multi;
  logic [3:0] mrg_idx;

  assign dwell_end = (dwell_cnt == '1);
  assign col       = ~(4'b0001 << col_sel);

  // Fold the current column's rows into the running scan result.
  always_comb begin
    lows      = ~row_s2;
    col_any   = 1'b0;
    col_multi = 1'b0;
    first_r   = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (lows[r]) begin
        if (col_any) col_multi = 1'b1;
        else         first_r   = 2'(r);
        col_any = 1'b1;
      end
    end
    mrg_any   = acc_any | col_any;
    mrg_multi = acc_multi | col_multi | (acc_any & col_any);
    mrg_idx   = acc_any ? acc_idx : {first_r, col_sel};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1    <= '1;
      row_s2    <= '1;
      dwell_cnt <= '0;
      col_sel   <= '0;
      acc_any   <= 1'b0;
      acc_multi <= 1'b0;
      acc_idx   <= '0;
      scan_done <= 1'b0;
      scan_kind <= SCAN_NONE;
      scan_idx  <= '0;
    end else begin
      row_s1    <= row;
      row_s2    <= row_s1;
      dwell_cnt <= dwell_cnt + SCAN_W'(1);
      scan_done <= 1'b0;
      if (dwell_end) begin
        col_sel <= col_sel + 2'd1;
        if (col_sel == 2'd3) begin
          scan_done <= 1'b1;
          scan_kind <= mrg_multi ? SCAN_MULTI : (mrg_any ? SCAN_SINGLE : SCAN_NONE);
          scan_idx  <= mrg_idx;
          acc_any   <= 1'b0;
          acc_multi <= 1'b0;
          acc_idx   <= '0;
        end else begin
          acc_any   <= mrg_any;
          acc_multi <= mrg_multi;
          acc_idx   <= mrg_idx;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad front end: debounces full-scan results into single key presses
// and assembles up to two decimal digits into a committed value.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int SCAN_W    = 17,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [7:0] entry_val,
  output logic [1:0] digit_cnt,
  output logic [7:0] num,
  output logic       num_valid
);

  localparam int CNT_W = $clog2(DEB_SCANS + 1);
  localparam logic [CNT_W-1:0] DEB_TGT = CNT_W'(DEB_SCANS);

  logic       scan_done;
  scan_kind_t scan_kind;
  logic [3:0] scan_idx;

  keypad_scan #(.SCAN_W(SCAN_W)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .scan_done (scan_done),
    .scan_kind (scan_kind),
    .scan_idx  (scan_idx)
  );

  deb_state_t       state, state_nx;
  logic [3:0]       cand, cand_nx;
  logic [CNT_W-1:0] deb_cnt, deb_cnt_nx, cnt_inc;
  logic             single, fire;
  logic [3:0]       first_digit;

  assign single  = (scan_kind == SCAN_SINGLE);
  assign cnt_inc = deb_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cand    <= '0;
      deb_cnt <= '0;
    end else begin
      state   <= state_nx;
      cand    <= cand_nx;
      deb_cnt <= deb_cnt_nx;
    end
  end

  // A multi-key scan is handled exactly like an empty one.
  always_comb begin
    state_nx   = state;
    cand_nx    = cand;
    deb_cnt_nx = deb_cnt;
    fire       = 1'b0;
    if (scan_done) begin
      case (state)
        ST_IDLE: if (single) begin
          state_nx   = ST_CAND;
          cand_nx    = scan_idx;
          deb_cnt_nx = CNT_W'(1);
        end
        ST_CAND: if (single && scan_idx == cand) begin
          deb_cnt_nx = cnt_inc;
          if (cnt_inc == DEB_TGT) begin
            state_nx = ST_HELD;
            fire     = 1'b1;
          end
        end else begin
          state_nx = ST_IDLE;
        end
        ST_HELD: if (!single) begin
          state_nx   = ST_REL;
          deb_cnt_nx = CNT_W'(1);
        end
        ST_REL: if (!single) begin
          deb_cnt_nx = cnt_inc;
          if (cnt_inc == DEB_TGT) state_nx = ST_IDLE;
        end else begin
          state_nx = ST_HELD;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= fire;
      if (fire) key_code <= keymap(cand);
    end
  end

  // The first digit is kept so backspace from two digits needs no divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_val   <= '0;
      digit_cnt   <= '0;
      first_digit <= '0;
      num         <= '0;
      num_valid   <= 1'b0;
    end else begin
      num_valid <= 1'b0;
      if (key_valid) begin
        if (key_code <= 4'd9) begin
          case (digit_cnt)
            2'd0: begin
              entry_val   <= {4'b0000, key_code};
              first_digit <= key_code;
              digit_cnt   <= 2'd1;
            end
            2'd1: begin
              entry_val <= mul10(entry_val) + {4'b0000, key_code};
              digit_cnt <= 2'd2;
            end
            default: ;
          endcase
        end else if (key_code == KEY_CLR) begin
          entry_val <= '0;
          digit_cnt <= '0;
        end else if (key_code == KEY_BS) begin
          case (digit_cnt)
            2'd2: begin
              entry_val <= {4'b0000, first_digit};
              digit_cnt <= 2'd1;
            end
            2'd1: begin
              entry_val <= '0;
              digit_cnt <= '0;
            end
            default: ;
          endcase
        end else if (key_code == KEY_ENT) begin
          if (digit_cnt != 2'd0) begin
            num       <= entry_val;
            num_valid <= 1'b1;
            entry_val <= '0;
            digit_cnt <= '0;
          end
        end
      end
    end
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter SCAN_W, default 17, column dwell of 2^SCAN_W clk cycles per column.
REQ-002 Parameter DEB_SCANS, default 4, consecutive identical full scans required to accept a press or a release.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 row  input  4  keypad rows, active-low, asynchronous, externally pulled up.
REQ-006 col  output  4  column strobes, active-low, exactly one low at a time.
REQ-007 key_valid  output  1  one-cycle pulse on each accepted key press.
REQ-008 key_code  output  4  decoded code of the last accepted key, held between pulses.
REQ-009 entry_val  output  8  live value being entered, 0..99 binary.
REQ-010 digit_cnt  output  2  digits currently entered, 0..2.
REQ-011 num  output  8  last committed value, 0..99, held until the next commit.
REQ-012 num_valid  output  1  one-cycle pulse when num is updated.

Function
REQ-013 row SHALL pass a 2-flop synchronizer before any use.
REQ-014 The dwell counter SHALL be free-running, SCAN_W bits; col SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110 on each counter wrap.
REQ-015 Synchronized rows SHALL be sampled only in the last cycle of each dwell; rows of column c, row r low give raw index r*4+c.
REQ-016 A full scan (4 dwells, ending on column 3) SHALL yield NONE, SINGLE(index) or MULTI; MULTI SHALL be treated as NONE.
REQ-017 Debounce FSM states: IDLE, CAND, HELD, REL.
REQ-018 IDLE: SINGLE(k) -> CAND, cand=k, cnt=1; otherwise stay.
REQ-019 CAND: SINGLE(k==cand) -> cnt+1, and on reaching DEB_SCANS -> HELD with key_valid pulse and key_code=keymap[cand]; any other result -> IDLE.
REQ-020 HELD: NONE -> REL, cnt=1; otherwise stay; held keys SHALL never auto-repeat.
REQ-021 REL: NONE -> cnt+1, and on reaching DEB_SCANS -> IDLE; any key -> HELD.
REQ-022 keymap: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E,0,F,D (codes 0-9 digits, A=clear, B=backspace, E=enter, C/D/F ignored).
REQ-023 Entry logic SHALL act only in the cycle key_valid is high, with results visible the next cycle.
REQ-024 Digit d: digit_cnt 0 -> entry_val=d, cnt 1; cnt 1 -> entry_val=10*prev+d, cnt 2; cnt 2 -> ignored.
REQ-025 Clear: entry_val=0, digit_cnt=0, num unchanged.
REQ-026 Backspace: cnt 2 -> entry_val=tens digit, cnt 1; cnt 1 -> entry_val=0, cnt 0; cnt 0 -> no-op.
REQ-027 Enter with cnt>0: num=entry_val, num_valid pulse, entry_val=0, digit_cnt=0; with cnt 0: ignored, no pulse.
REQ-028 The multiply by 10 SHALL be done as (x<<3)+(x<<1) in 8 bits; results never exceed 99.

Reset
REQ-029 On rst, all outputs SHALL be zero except col=1110: dwell counter 0, FSM IDLE, key_code 0, entry_val 0, digit_cnt 0, num 0, key_valid 0, num_valid 0.
REQ-030 rst asserted mid-debounce or mid-entry SHALL discard the partial state; a key held through reset SHALL be accepted only after DEB_SCANS full scans.

Structure
REQ-031 A shared package SHALL hold the key code constants (KEY_CLR, KEY_BS, KEY_ENT), the keymap table and the FSM state enum.
REQ-032 One sub-module keypad_scan (synchronizer, dwell counter, col rotation, scan result) is natural; debounce and entry stay in keypad_entry.

Verification (SCAN_W=2, DEB_SCANS=2)
REQ-033 Press '4' (row1, col0) for 3 full scans, then release -> exactly one key_valid, key_code=4, entry_val=4, digit_cnt=1.
REQ-034 Keys 7,3,5,enter -> entry_val 7, then 73; 5 ignored; num=73 with one num_valid pulse; entry_val=0, digit_cnt=0.
REQ-035 Press 9 held for one scan only (bounce) -> no key_valid; two keys pressed in the same scan -> no key_valid.
REQ-036 Keys 4,2,B,B,B -> entry_val 42, then 4, then 0, then 0, with digit_cnt 2,1,0,0; enter -> no num_valid.
REQ-037 Key 8 held for 20 scans -> single key_valid; a release glitch of 1 scan -> no second press.
REQ-038 rst pulse after digits 1,6 -> entry_val=0, num=0, col=1110 on the next cycle.
